// File: rtl/dac_axis_buffer.sv
// dac_axis_buffer: sample FIFO between the DAC controller sample mux and the
// RFDC DAC AXIS input. The FIFO is primed before streaming starts. Once
// streaming, tvalid stays high and a fill sample is substituted whenever the
// FIFO runs dry; each accepted fill beat is counted as an underrun. Beats
// offered while the FIFO is full are dropped and flagged as overflow.
// Optional feature macro: DAC_BUF_HOLD_LAST_EN (fill sample = last popped
// word instead of all-zero).
module dac_axis_buffer #(
    parameter int unsigned AXIS_DATA_WIDTH = 256,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH      = 4,
    parameter int unsigned PRIME_LEVEL     = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m00_axis_tdata,
    output logic                       m00_axis_tvalid,
    input  logic                       m00_axis_tready,
    output logic [ADDR_WIDTH:0]        fifo_level,
    output logic [31:0]                underrun_count,
    output logic                       overflow
);

    localparam int unsigned PTR_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        UNDERRUN = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [AXIS_DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]         wr_ptr;
    logic [PTR_WIDTH-1:0]         rd_ptr;
    logic [PTR_WIDTH-1:0]         wr_ptr_next;
    logic [PTR_WIDTH-1:0]         rd_ptr_next;
    logic                         full_next;
    logic                         push;
    logic                         pop;
    logic                         empty;
    logic                         advance;
    logic                         load;
    logic                         tvalid_next;
    logic                         count_fill;
    logic [AXIS_DATA_WIDTH-1:0]   head;
    logic [AXIS_DATA_WIDTH-1:0]   fill;
    logic [AXIS_DATA_WIDTH-1:0]   load_data;

    assign push    = s_axis_tvalid && s_axis_tready;
    assign empty   = (wr_ptr == rd_ptr);
    assign advance = !m00_axis_tvalid || m00_axis_tready;
    assign head    = mem[rd_ptr[ADDR_WIDTH-1:0]];

    assign wr_ptr_next = wr_ptr + PTR_WIDTH'(push);
    assign rd_ptr_next = rd_ptr + PTR_WIDTH'(pop);
    assign full_next   = (wr_ptr_next[ADDR_WIDTH] != rd_ptr_next[ADDR_WIDTH]) &&
                         (wr_ptr_next[ADDR_WIDTH-1:0] == rd_ptr_next[ADDR_WIDTH-1:0]);

`ifdef DAC_BUF_HOLD_LAST_EN
    logic [AXIS_DATA_WIDTH-1:0] last_word;

    // Remember the last real sample so underruns hold the DAC level
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            last_word <= '0;
        end else if (pop) begin
            last_word <= head;
        end
    end

    assign fill = last_word;
`else
    assign fill = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, pop and output-register load decisions
    always_comb begin
        state_next  = state;
        pop         = 1'b0;
        load        = 1'b0;
        load_data   = head;
        tvalid_next = m00_axis_tvalid;
        count_fill  = 1'b0;
        case (state)
            IDLE: begin
                tvalid_next = 1'b0;
                if (fifo_level >= PTR_WIDTH'(PRIME_LEVEL)) begin
                    pop         = 1'b1;
                    load        = 1'b1;
                    tvalid_next = 1'b1;
                    state_next  = STREAM;
                end
            end
            STREAM: begin
                tvalid_next = 1'b1;
                if (advance) begin
                    load = 1'b1;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        load_data  = fill;
                        state_next = UNDERRUN;
                    end
                end
            end
            UNDERRUN: begin
                tvalid_next = 1'b1;
                count_fill  = m00_axis_tready;
                if (advance) begin
                    load = 1'b1;
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = STREAM;
                    end else begin
                        load_data = fill;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
        end
    end

    // Pointers, occupancy and input ready
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            s_axis_tready <= 1'b1;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            fifo_level    <= wr_ptr_next - rd_ptr_next;
            s_axis_tready <= !full_next;
        end
    end

    // Output beat register
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            m00_axis_tdata  <= '0;
            m00_axis_tvalid <= 1'b0;
        end else begin
            m00_axis_tvalid <= tvalid_next;
            if (load) begin
                m00_axis_tdata <= load_data;
            end
        end
    end

    // Saturating count of fill beats accepted by the DAC
    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_count <= '0;
        end else if (count_fill && !flush && (underrun_count != 32'hFFFF_FFFF)) begin
            underrun_count <= underrun_count + 32'd1;
        end
    end

    // Sticky flag for beats dropped while the FIFO was full
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (s_axis_tvalid && !s_axis_tready) begin
            overflow <= 1'b1;
        end
    end

endmodule
